alt_vipvfr131_common_sample_serializer: RTL and testbench
=========================================================

Name: alt_vipvfr131_common_sample_serializer

Overview:
- Transmit-side counterpart to the sample-counting logic on the receive path. Accepts one whole pixel sample per handshake, with all colour planes in parallel.
- Emits the sample as NUMBER_OF_COLOUR_PLANES sequential beats, one plane per beat, on a valid/ready stream. When hd_sdn is asserted it passes the sample through as a single parallel beat.
- Sits in front of the Avalon-ST video output to produce colour-plane-sequential streams. Publishes the running plane index.

Parameters:
- NUMBER_OF_COLOUR_PLANES, 3: planes per sample; legal range 1..8.
- BITS_PER_SYMBOL, 8: bits per colour plane.
- LOG2_NUMBER_OF_COLOUR_PLANES, 2: width of the plane index; must be >= 1 and satisfy 2**LOG2 >= NUMBER_OF_COLOUR_PLANES.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sclr  in  1  synchronous clear; highest priority after reset.
- hd_sdn  in  1  1 = parallel mode (one beat per sample); 0 = sequential mode.
- din_valid  in  1  input sample valid.
- din_ready  out  1  input sample accepted when din_valid & din_ready.
- din_data  in  BITS_PER_SYMBOL*NUMBER_OF_COLOUR_PLANES  whole sample; plane 0 in the LSBs.
- din_sop  in  1  first sample of packet.
- din_eop  in  1  last sample of packet.
- dout_valid  out  1  output beat valid.
- dout_ready  in  1  downstream accepts the beat when dout_valid & dout_ready.
- dout_data  out  BITS_PER_SYMBOL*NUMBER_OF_COLOUR_PLANES  output beat. In sequential mode only the low BITS_PER_SYMBOL bits carry data and the upper bits are 0.
- dout_sop  out  1  asserted on the first beat of a sop sample.
- dout_eop  out  1  asserted on the last beat of an eop sample.
- sample_ticks  out  LOG2_NUMBER_OF_COLOUR_PLANES  plane index of the current dout beat.

Behaviour:
- Reset values: dout_valid=0, dout_data=0, dout_sop=0, dout_eop=0, sample_ticks=0. din_ready=1 as soon as rst_n deasserts, because the holding register is empty.
- Structure: a single holding register plus a plane counter cnt. Two states:
  - EMPTY: dout_valid=0.
  - HOLD: dout_valid=1.
- last_beat = (mode_l == 1) | (cnt == NUMBER_OF_COLOUR_PLANES-1), where mode_l is hd_sdn latched when the sample is accepted. hd_sdn changes while in HOLD are ignored.
- din_ready = (state==EMPTY) | (dout_ready & last_beat). This gives full throughput: back-to-back samples have no bubble beat.
- Accept (din_valid & din_ready):
  - Load the register with din_data; latch sop, eop and mode_l; set cnt=0.
  - Go to HOLD. dout_valid rises the next cycle (latency 1).
- Beat transfer in HOLD (dout_valid & dout_ready):
  - If !last_beat: shift the register right by BITS_PER_SYMBOL and increment cnt.
  - If last_beat: go to EMPTY, unless a new sample is accepted in the same cycle, in which case reload and stay in HOLD.
- Output alignment:
  - dout_data = low plane of the register in sequential mode; the full register in parallel mode.
  - dout_sop = sop_l & (cnt==0).
  - dout_eop = eop_l & last_beat.
  - sample_ticks = cnt; it is 0 in parallel mode.
- While dout_valid=1 and dout_ready=0, dout_data, dout_sop, dout_eop and sample_ticks hold stable.
- NUMBER_OF_COLOUR_PLANES==1: last_beat is constant 1, the design is a 1-deep register slice, and sample_ticks=0.
- sclr: next cycle state=EMPTY and cnt=0. Any in-flight sample is dropped. A din handshake in the sclr cycle is discarded. dout_valid=0 the cycle after sclr.
- Reset mid-sample: asynchronous return to reset values. The partial sample is lost.
- cnt never exceeds NUMBER_OF_COLOUR_PLANES-1 and wraps to 0 only through a reload.

Optional Feature:
- Macro SAMPLE_SERIALIZER_MSB_FIRST_EN.
- When defined: sequential beats are emitted from plane N-1 down to plane 0. The register shifts left and dout_data takes the top BITS_PER_SYMBOL bits, moved to the LSBs. sample_ticks still counts 0..N-1 in beat order.
- When undefined: plane 0 is emitted first (the default above). Parallel mode is identical either way.

Test Plan:
- N=3, BPS=8, hd_sdn=0, dout_ready=1, one sample din_data=0x332211 with sop=eop=1 -> dout_data 0x11, 0x22, 0x33 on three consecutive cycles starting 1 cycle after accept. sample_ticks 0,1,2; sop on beat 0 only; eop on beat 2 only.
- Two back-to-back samples 0x332211 and 0x665544, dout_ready=1 -> six consecutive beats 11,22,33,44,55,66 with no gap. din_ready=1 on the cycle of the beat 0x33.
- Backpressure: dout_ready=0 for 4 cycles during beat 1 -> dout_data stays 0x22, sample_ticks stays 1, din_ready=0 throughout, and no beat is lost.
- hd_sdn=1, samples 0xAABBCC and 0x112233 -> one beat each with full-width data 0xAABBCC, then 0x112233. sample_ticks=0; sop and eop on the same beat.
- sclr asserted while holding beat 1 -> dout_valid=0 next cycle and din_ready=1. A following sample 0x030201 emits 01,02,03 with sample_ticks 0,1,2.
- rst_n pulsed low mid-sample -> all outputs return to reset values immediately (asynchronously). With SAMPLE_SERIALIZER_MSB_FIRST_EN defined, 0x332211 emits 33,22,11.

Source files
------------

// File: rtl/alt_vipvfr131_common_sample_serializer.sv
// Serialises one parallel pixel sample into colour-plane-sequential beats, or passes it through in parallel mode.
// Optional macro SAMPLE_SERIALIZER_MSB_FIRST_EN: emit plane N-1 first instead of plane 0.
module alt_vipvfr131_common_sample_serializer #(
    parameter int unsigned NUMBER_OF_COLOUR_PLANES      = 3,
    parameter int unsigned BITS_PER_SYMBOL              = 8,
    parameter int unsigned LOG2_NUMBER_OF_COLOUR_PLANES = 2
) (
    input  logic                                                clk,
    input  logic                                                rst_n,
    input  logic                                                sclr,
    input  logic                                                hd_sdn,
    input  logic                                                din_valid,
    output logic                                                din_ready,
    input  logic [BITS_PER_SYMBOL*NUMBER_OF_COLOUR_PLANES-1:0]  din_data,
    input  logic                                                din_sop,
    input  logic                                                din_eop,
    output logic                                                dout_valid,
    input  logic                                                dout_ready,
    output logic [BITS_PER_SYMBOL*NUMBER_OF_COLOUR_PLANES-1:0]  dout_data,
    output logic                                                dout_sop,
    output logic                                                dout_eop,
    output logic [LOG2_NUMBER_OF_COLOUR_PLANES-1:0]             sample_ticks
);

    localparam int unsigned W  = BITS_PER_SYMBOL * NUMBER_OF_COLOUR_PLANES;
    localparam int unsigned BW = BITS_PER_SYMBOL;
    localparam int unsigned CW = LOG2_NUMBER_OF_COLOUR_PLANES;
    localparam logic [CW-1:0] LAST_CNT = CW'(NUMBER_OF_COLOUR_PLANES - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic [W-1:0]  data_q, data_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          sop_l, sop_nxt;
    logic          eop_l, eop_nxt;
    logic          mode_l, mode_nxt;

    logic          last_beat;
    logic          accept;
    logic          xfer;
    logic [W-1:0]  shifted;
    logic [BW-1:0] plane;

    // Plane ordering: which end of the holding register is presented and which way it moves
`ifdef SAMPLE_SERIALIZER_MSB_FIRST_EN
    assign shifted = data_q << BW;
    assign plane   = data_q[W-1 -: BW];
`else
    assign shifted = data_q >> BW;
    assign plane   = data_q[BW-1:0];
`endif

    assign last_beat = mode_l | (cnt == LAST_CNT);
    assign din_ready = (state == EMPTY) | (dout_ready & last_beat);
    assign accept    = din_valid & din_ready;
    assign xfer      = (state == HOLD) & dout_ready;

    // Next-state: sclr beats a reload, a reload beats a shift
    always_comb begin
        state_nxt = state;
        data_nxt  = data_q;
        cnt_nxt   = cnt;
        sop_nxt   = sop_l;
        eop_nxt   = eop_l;
        mode_nxt  = mode_l;
        if (sclr) begin
            state_nxt = EMPTY;
            cnt_nxt   = '0;
        end else if (accept) begin
            state_nxt = HOLD;
            data_nxt  = din_data;
            cnt_nxt   = '0;
            sop_nxt   = din_sop;
            eop_nxt   = din_eop;
            mode_nxt  = hd_sdn;
        end else if (xfer) begin
            if (last_beat) begin
                state_nxt = EMPTY;
            end else begin
                data_nxt = shifted;
                cnt_nxt  = cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= EMPTY;
            data_q <= '0;
            cnt    <= '0;
            sop_l  <= 1'b0;
            eop_l  <= 1'b0;
            mode_l <= 1'b0;
        end else begin
            state  <= state_nxt;
            data_q <= data_nxt;
            cnt    <= cnt_nxt;
            sop_l  <= sop_nxt;
            eop_l  <= eop_nxt;
            mode_l <= mode_nxt;
        end
    end

    // Outputs come straight off the holding registers, so they are stable under backpressure
    assign dout_valid   = (state == HOLD);
    assign dout_data    = mode_l ? data_q : W'(plane);
    assign dout_sop     = (state == HOLD) & sop_l & (cnt == '0);
    assign dout_eop     = (state == HOLD) & eop_l & last_beat;
    assign sample_ticks = cnt;

endmodule

// File: tb/tb_alt_vipvfr131_common_sample_serializer.sv
// Self-checking bench for the sample serializer: vector table plus scoreboard, with hand sequences for corner cases.
module tb_alt_vipvfr131_common_sample_serializer;

    localparam int unsigned N   = 3;
    localparam int unsigned BPS = 8;
    localparam int unsigned LG  = 2;
    localparam int unsigned W   = N * BPS;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sclr;
    logic          hd_sdn;
    logic          din_valid;
    logic          din_ready;
    logic [W-1:0]  din_data;
    logic          din_sop;
    logic          din_eop;
    logic          dout_valid;
    logic          dout_ready;
    logic [W-1:0]  dout_data;
    logic          dout_sop;
    logic          dout_eop;
    logic [LG-1:0] sample_ticks;

    alt_vipvfr131_common_sample_serializer #(
        .NUMBER_OF_COLOUR_PLANES     (N),
        .BITS_PER_SYMBOL             (BPS),
        .LOG2_NUMBER_OF_COLOUR_PLANES(LG)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sclr        (sclr),
        .hd_sdn      (hd_sdn),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .din_data    (din_data),
        .din_sop     (din_sop),
        .din_eop     (din_eop),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .dout_data   (dout_data),
        .dout_sop    (dout_sop),
        .dout_eop    (dout_eop),
        .sample_ticks(sample_ticks)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0]  data;
        logic [LG-1:0] ticks;
        logic          sop;
        logic          eop;
    } beat_t;

    // Input sample plus its expected beats, listed plane 0 first (e0 is the full word in parallel mode)
    typedef struct {
        logic [W-1:0] din;
        logic         hd;
        logic         sop;
        logic         eop;
        logic [W-1:0] e0;
        logic [W-1:0] e1;
        logic [W-1:0] e2;
    } vec_t;

    beat_t sbq[$];
    beat_t held;
    vec_t  cur;
    vec_t  vecs[8];
    logic  stall_pending = 1'b0;
    logic  accepted      = 1'b0;
    int    n_checks      = 0;
    int    n_pass        = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    endtask

    function automatic logic [W-1:0] plane_exp(input vec_t v, input int p);
        case (p)
            0:       return v.e0;
            1:       return v.e1;
            default: return v.e2;
        endcase
    endfunction

    task automatic push_expected(input vec_t v);
        beat_t b;
        int    p;
        if (v.hd) begin
            b = '{v.e0, LG'(0), v.sop, v.eop};
            sbq.push_back(b);
        end else begin
            for (int i = 0; i < int'(N); i++) begin
`ifdef SAMPLE_SERIALIZER_MSB_FIRST_EN
                p = int'(N) - 1 - i;
`else
                p = i;
`endif
                b = '{plane_exp(v, p), LG'(i), v.sop && (i == 0), v.eop && (i == int'(N) - 1)};
                sbq.push_back(b);
            end
        end
    endtask

    task automatic set_in(input vec_t v);
        cur      = v;
        din_data = v.din;
        hd_sdn   = v.hd;
        din_sop  = v.sop;
        din_eop  = v.eop;
    endtask

    // One clock: sample outputs 1 time unit after the falling edge, score them, then wait for the next falling edge
    task automatic tick();
        beat_t c;
        beat_t e;
        #1;
        c = '{dout_data, sample_ticks, dout_sop, dout_eop};
        if (stall_pending) check("hold_stable", 64'(c), 64'(held));
        stall_pending = 1'b0;
        accepted      = 1'b0;
        if (dout_valid) begin
            if (!dout_ready) begin
                held          = c;
                stall_pending = 1'b1;
            end else if (sbq.size() == 0) begin
                check("beat_expected", 64'(sbq.size()), 64'd1);
            end else begin
                e = sbq.pop_front();
                check("beat", 64'(c), 64'(e));
            end
        end
        if (sclr) begin
            sbq.delete();
            stall_pending = 1'b0;
        end else if (din_valid && din_ready) begin
            push_expected(cur);
            accepted = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic send(input vec_t v, input logic rand_ready);
        int k;
        set_in(v);
        din_valid = 1'b1;
        k = 0;
        do begin
            if (rand_ready) dout_ready = ($urandom_range(0, 3) != 0);
            tick();
            k++;
        end while (!accepted && k < 40);
        if (!accepted) check("accept_timeout", 64'(k), 64'd0);
        din_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        dout_ready = 1'b1;
        k = 0;
        while (sbq.size() != 0 && k < 40) begin
            tick();
            k++;
        end
        check("drain_empty", 64'(sbq.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench still running at t=%0t, expected to finish", $time);
        $fatal(1);
    end

    initial begin
        vec_t b2b0, b2b1, bp, clr, rv;

        vecs[0] = '{24'h332211, 1'b0, 1'b1, 1'b1, 24'h11, 24'h22, 24'h33};
        vecs[1] = '{24'h665544, 1'b0, 1'b1, 1'b0, 24'h44, 24'h55, 24'h66};
        vecs[2] = '{24'h998877, 1'b0, 1'b0, 1'b1, 24'h77, 24'h88, 24'h99};
        vecs[3] = '{24'hAABBCC, 1'b1, 1'b1, 1'b1, 24'hAABBCC, 24'h0, 24'h0};
        vecs[4] = '{24'h112233, 1'b1, 1'b1, 1'b1, 24'h112233, 24'h0, 24'h0};
        vecs[5] = '{24'h0000FF, 1'b0, 1'b0, 1'b0, 24'hFF, 24'h00, 24'h00};
        vecs[6] = '{24'h123456, 1'b1, 1'b0, 1'b1, 24'h123456, 24'h0, 24'h0};
        vecs[7] = '{24'h807F01, 1'b0, 1'b1, 1'b1, 24'h01, 24'h7F, 24'h80};

        rst_n      = 1'b0;
        sclr       = 1'b0;
        hd_sdn     = 1'b0;
        din_valid  = 1'b0;
        din_data   = '0;
        din_sop    = 1'b0;
        din_eop    = 1'b0;
        dout_ready = 1'b0;
        cur        = vecs[0];
        #12;
        check("rst_dout_valid", 64'(dout_valid), 64'd0);
        check("rst_dout_data", 64'(dout_data), 64'd0);
        check("rst_dout_sop", 64'(dout_sop), 64'd0);
        check("rst_dout_eop", 64'(dout_eop), 64'd0);
        check("rst_sample_ticks", 64'(sample_ticks), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_din_ready", 64'(din_ready), 64'd1);
        @(negedge clk);

        // Table pass: every vector, random downstream backpressure
        foreach (vecs[i]) send(vecs[i], 1'b1);
        drain();
        repeat (2) tick();

        // Back-to-back samples: six beats with no bubble, second accept on the third beat
        b2b0 = vecs[0];
        b2b1 = vecs[1];
        dout_ready = 1'b1;
        set_in(b2b0);
        din_valid = 1'b1;
        tick();
        check("b2b_first_accept", 64'(accepted), 64'd1);
        set_in(b2b1);
        for (int k = 0; k < 6; k++) begin
            check("b2b_no_gap", 64'(dout_valid), 64'd1);
            if (k == 2) check("b2b_ready_on_last", 64'(din_ready), 64'd1);
            tick();
            if (k == 2) din_valid = 1'b0;
        end
        check("b2b_idle_after", 64'(dout_valid), 64'd0);
        drain();

        // Backpressure on beat 1
        bp = vecs[2];
        send(bp, 1'b0);
        tick();
        dout_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("bp_ticks", 64'(sample_ticks), 64'd1);
            check("bp_din_ready", 64'(din_ready), 64'd0);
            tick();
        end
        drain();

        // sclr while holding beat 1 drops the sample
        clr = vecs[1];
        dout_ready = 1'b1;
        send(clr, 1'b0);
        tick();
        dout_ready = 1'b0;
        sclr = 1'b1;
        tick();
        sclr = 1'b0;
        check("sclr_valid_low", 64'(dout_valid), 64'd0);
        check("sclr_din_ready", 64'(din_ready), 64'd1);
        check("sclr_ticks", 64'(sample_ticks), 64'd0);
        send('{24'h030201, 1'b0, 1'b1, 1'b1, 24'h01, 24'h02, 24'h03}, 1'b0);
        drain();

        // Asynchronous reset mid-sample
        rv = vecs[7];
        dout_ready = 1'b1;
        send(rv, 1'b0);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_dout_valid", 64'(dout_valid), 64'd0);
        check("arst_dout_data", 64'(dout_data), 64'd0);
        check("arst_dout_sop", 64'(dout_sop), 64'd0);
        check("arst_dout_eop", 64'(dout_eop), 64'd0);
        check("arst_sample_ticks", 64'(sample_ticks), 64'd0);
        check("arst_din_ready", 64'(din_ready), 64'd1);
        sbq.delete();
        stall_pending = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(vecs[0], 1'b0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
